sel_encode_seq: RTL and testbench

//   Parametrised select-and-encode unit for the datapath control. Holds its own instruction

---
 rtl/sel_encode_seq.sv | 168 ++++++++++++++++
 tb/tb_sel_encode_seq.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sel_encode_seq.sv
// Select-and-encode unit: owns the instruction register, decodes its fields,
// and drives registered one-hot register-file enables either from the manual
// Gra/Grb/Grc controls or from a built-in read-B / read-C / write-A sequencer.
//
//   state | meaning
//   ------+-----------------------------------------------
//   IDLE  | manual select path active, IR may be loaded
//   RD_B  | drive reg_out for Rb
//   RD_C  | drive reg_out for Rc (skipped for immediate ops)
//   WR_A  | drive reg_in for Ra
//   DONE  | one-cycle seq_done pulse, then back to IDLE
module sel_encode_seq #(
  parameter int DATA_W    = 32,
  parameter int OPC_W     = 5,
  parameter int REG_IDX_W = 4,
  parameter int NUM_REGS  = 16,
  parameter int IMM_W     = 19
) (
  input  logic                 clock,
  input  logic                 clear,
  input  logic                 ir_load,
  input  logic [DATA_W-1:0]    instr_in,
  input  logic                 Gra,
  input  logic                 Grb,
  input  logic                 Grc,
  input  logic                 Rin,
  input  logic                 Rout,
  input  logic                 BAout,
  input  logic                 seq_start,
  input  logic                 seq_skip_c,
  output logic [OPC_W-1:0]     opcode,
  output logic [DATA_W-1:0]    C_sign_extended,
  output logic [NUM_REGS-1:0]  reg_in,
  output logic [NUM_REGS-1:0]  reg_out,
  output logic [REG_IDX_W-1:0] reg_index,
  output logic                 ba_zero,
  output logic                 conflict,
  output logic                 seq_busy,
  output logic                 seq_done
);

  localparam int RA_MSB = DATA_W - OPC_W - 1;
  localparam int RB_MSB = RA_MSB - REG_IDX_W;
  localparam int RC_MSB = RB_MSB - REG_IDX_W;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_RD_B = 3'd1,
    S_RD_C = 3'd2,
    S_WR_A = 3'd3,
    S_DONE = 3'd4
  } state_t;

  state_t                state_q, state_d;
  logic [DATA_W-1:0]     ir_q;
  logic                  skip_q;
  logic [NUM_REGS-1:0]   reg_in_q, reg_in_d;
  logic [NUM_REGS-1:0]   reg_out_q, reg_out_d;
  logic [REG_IDX_W-1:0]  idx_q, idx_d;
  logic                  ba_q, ba_d;
  logic                  conf_q, conf_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;

  logic [REG_IDX_W-1:0]  ra, rb, rc, man_idx;
  logic [NUM_REGS-1:0]   onehot;
  logic                  want_in, want_out;

  assign ra              = ir_q[RA_MSB -: REG_IDX_W];
  assign rb              = ir_q[RB_MSB -: REG_IDX_W];
  assign rc              = ir_q[RC_MSB -: REG_IDX_W];
  assign opcode          = ir_q[DATA_W-1 -: OPC_W];
  assign C_sign_extended = {{(DATA_W-IMM_W){ir_q[IMM_W-1]}}, ir_q[IMM_W-1:0]};

  assign reg_in    = reg_in_q;
  assign reg_out   = reg_out_q;
  assign reg_index = idx_q;
  assign ba_zero   = ba_q;
  assign conflict  = conf_q;
  assign seq_busy  = busy_q;
  assign seq_done  = done_q;

  // Manual field select: Gra beats Grb beats Grc, nothing selected means R0.
  always_comb begin
    man_idx = '0;
    if (Gra)      man_idx = ra;
    else if (Grb) man_idx = rb;
    else if (Grc) man_idx = rc;
  end

  // Sequencer next state; ir_load in IDLE takes precedence over seq_start.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (seq_start && !ir_load) state_d = S_RD_B;
      S_RD_B:  state_d = skip_q ? S_WR_A : S_RD_C;
      S_RD_C:  state_d = S_WR_A;
      S_WR_A:  state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they appear in the cycle that
  // the state is entered; manual controls count only when staying in IDLE.
  always_comb begin
    idx_d    = '0;
    want_in  = 1'b0;
    want_out = 1'b0;
    done_d   = 1'b0;
    case (state_d)
      S_RD_B: begin
        idx_d    = rb;
        want_out = 1'b1;
      end
      S_RD_C: begin
        idx_d    = rc;
        want_out = 1'b1;
      end
      S_WR_A: begin
        idx_d   = ra;
        want_in = 1'b1;
      end
      S_DONE:  done_d = 1'b1;
      default: begin
        if (state_q == S_IDLE) begin
          idx_d    = man_idx;
          want_in  = Rin;
          want_out = Rout;
        end
      end
    endcase
    onehot    = {{(NUM_REGS-1){1'b0}}, 1'b1} << idx_d;
    ba_d      = want_out && BAout && (idx_d == '0);
    reg_out_d = (want_out && !ba_d) ? onehot : '0;
    reg_in_d  = want_in ? onehot : '0;
    conf_d    = (|reg_in_d) & (|reg_out_d);
    busy_d    = (state_d != S_IDLE);
  end

  // State, IR and registered outputs; clear overrides everything.
  always_ff @(posedge clock) begin
    if (clear) begin
      state_q   <= S_IDLE;
      ir_q      <= '0;
      skip_q    <= 1'b0;
      reg_in_q  <= '0;
      reg_out_q <= '0;
      idx_q     <= '0;
      ba_q      <= 1'b0;
      conf_q    <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      if (ir_load && state_q == S_IDLE) ir_q <= instr_in;
      if (state_q == S_IDLE && state_d == S_RD_B) skip_q <= seq_skip_c;
      reg_in_q  <= reg_in_d;
      reg_out_q <= reg_out_d;
      idx_q     <= idx_d;
      ba_q      <= ba_d;
      conf_q    <= conf_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

endmodule

// File: tb/tb_sel_encode_seq.sv
// Bench for sel_encode_seq: directed scenarios with spec constants plus a
// randomized run against a step-list reference model.
module tb_sel_encode_seq;

  logic        clock = 1'b0;
  logic        clear, ir_load, Gra, Grb, Grc, Rin, Rout, BAout, seq_start, seq_skip_c;
  logic [31:0] instr_in;
  logic [4:0]  opcode;
  logic [31:0] C_sign_extended;
  logic [15:0] reg_in, reg_out;
  logic [3:0]  reg_index;
  logic        ba_zero, conflict, seq_busy, seq_done;

  int errors = 0;
  int checks = 0;

  sel_encode_seq dut (
    .clock(clock), .clear(clear), .ir_load(ir_load), .instr_in(instr_in),
    .Gra(Gra), .Grb(Grb), .Grc(Grc), .Rin(Rin), .Rout(Rout), .BAout(BAout),
    .seq_start(seq_start), .seq_skip_c(seq_skip_c),
    .opcode(opcode), .C_sign_extended(C_sign_extended),
    .reg_in(reg_in), .reg_out(reg_out), .reg_index(reg_index),
    .ba_zero(ba_zero), .conflict(conflict), .seq_busy(seq_busy), .seq_done(seq_done)
  );

  always #5 clock = ~clock;

  // Reference model: IR value plus a list of pending sequencer steps.
  // Step codes: 1 read Rb, 2 read Rc, 3 write Ra, 4 done pulse, 5 return to idle.
  logic [31:0] m_ir = 0;
  int          steps[$];
  logic [15:0] e_in, e_out;
  logic [3:0]  e_idx;
  logic        e_ba, e_conf, e_busy, e_done;

  function automatic logic [3:0] fld(logic [31:0] ir, int n);
    return 4'((ir >> (23 - 4 * n)) & 32'hF);
  endfunction

  function automatic logic [31:0] sext(logic [31:0] ir);
    logic [31:0] c;
    c = ir & 32'h7FFFF;
    if ((c & 32'h40000) != 0) c = c | 32'hFFF80000;
    return c;
  endfunction

  task automatic model_edge();
    int  st;
    int  idx;
    bit  w_in, w_out;
    if (clear) begin
      m_ir = 0;
      steps.delete();
      {e_in, e_out, e_idx, e_ba, e_conf, e_busy, e_done} = '0;
      return;
    end
    idx = 0; w_in = 0; w_out = 0; st = 0;
    if (steps.size() != 0) begin
      st = steps.pop_front();
    end else begin
      if (Gra) idx = fld(m_ir, 0);
      else if (Grb) idx = fld(m_ir, 1);
      else if (Grc) idx = fld(m_ir, 2);
      w_in = Rin; w_out = Rout;
      if (ir_load) m_ir = instr_in;
      else if (seq_start) begin
        steps = seq_skip_c ? '{1, 3, 4, 5} : '{1, 2, 3, 4, 5};
        st = steps.pop_front();
        w_in = 0; w_out = 0; idx = 0;
      end
    end
    case (st)
      1: begin idx = fld(m_ir, 1); w_out = 1; end
      2: begin idx = fld(m_ir, 2); w_out = 1; end
      3: begin idx = fld(m_ir, 0); w_in = 1; end
      default: ;
    endcase
    e_ba   = w_out && BAout && idx == 0;
    e_out  = (w_out && !e_ba) ? 16'(1 << idx) : 16'h0;
    e_in   = w_in ? 16'(1 << idx) : 16'h0;
    e_idx  = 4'(idx);
    e_conf = (e_in != 0) && (e_out != 0);
    e_busy = (st >= 1 && st <= 4);
    e_done = (st == 4);
  endtask

  task automatic cyc();
    @(posedge clock);
    model_edge();
    #1;
  endtask

  task automatic quiet();
    {clear, ir_load, Gra, Grb, Grc, Rin, Rout, BAout, seq_start, seq_skip_c} = '0;
    instr_in = 0;
  endtask

  task automatic load(logic [31:0] v);
    quiet();
    ir_load = 1; instr_in = v;
    cyc();
    quiet();
  endtask

  task automatic test_reset();
    clear = 1;
    for (int i = 0; i < 2; i++) begin
      {ir_load, Gra, Grb, Grc, Rin, Rout, BAout, seq_start, seq_skip_c} = 9'($urandom);
      instr_in = $urandom;
      cyc();
    end
    checks++;
    if ({reg_in, reg_out, reg_index, ba_zero, conflict, seq_busy, seq_done} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: in=%h out=%h idx=%0d ba=%b cf=%b busy=%b done=%b, required all 0",
               reg_in, reg_out, reg_index, ba_zero, conflict, seq_busy, seq_done);
    end
    checks++;
    if (opcode !== 0 || C_sign_extended !== 0) begin
      errors++;
      $display("FAIL reset_ir: opcode=%0d C=%h, required 0 and 0", opcode, C_sign_extended);
    end
    quiet();
  endtask

  task automatic test_decode();
    load(32'h1A938000);
    checks++;
    if (opcode !== 5'd3) begin errors++; $display("FAIL decode_opcode: got %0d required 3", opcode); end
    checks++;
    if (C_sign_extended !== 32'h00038000) begin
      errors++; $display("FAIL decode_c: got %h required 00038000", C_sign_extended);
    end
    Gra = 1; Rin = 1; cyc(); quiet();
    checks++;
    if (reg_in !== 16'h0020 || reg_out !== 0 || reg_index !== 4'd5) begin
      errors++; $display("FAIL manual_gra_rin: in=%h out=%h idx=%0d required 0020 0000 5", reg_in, reg_out, reg_index);
    end
    Grb = 1; Grc = 1; Rout = 1; cyc(); quiet();
    checks++;
    if (reg_out !== 16'h0004 || reg_in !== 0 || reg_index !== 4'd2) begin
      errors++; $display("FAIL manual_grb_prio: out=%h in=%h idx=%0d required 0004 0000 2", reg_out, reg_in, reg_index);
    end
    cyc();
    checks++;
    if (reg_out !== 0 || reg_in !== 0) begin
      errors++; $display("FAIL manual_release: out=%h in=%h required 0 0", reg_out, reg_in);
    end
  endtask

  task automatic test_sign_ext();
    load(32'h0007FFFF);
    checks++;
    if (C_sign_extended !== 32'hFFFFFFFF) begin
      errors++; $display("FAIL sign_ext: got %h required FFFFFFFF", C_sign_extended);
    end
    Grc = 1; Rout = 1; cyc(); quiet();
    checks++;
    if (reg_out !== 16'h8000 || reg_index !== 4'd15) begin
      errors++; $display("FAIL rc15: out=%h idx=%0d required 8000 15", reg_out, reg_index);
    end
  endtask

  task automatic test_sequence(bit skip);
    logic [15:0] x_out[5];
    logic [15:0] x_in[5];
    logic        x_busy[5];
    logic        x_done[5];
    int          n;
    load(32'h1A938000);
    if (skip) begin
      x_out = '{16'h0004, 16'h0, 16'h0, 16'h0, 16'h0};
      x_in  = '{16'h0, 16'h0020, 16'h0, 16'h0, 16'h0};
      x_busy = '{1, 1, 1, 0, 0}; x_done = '{0, 0, 1, 0, 0}; n = 4;
    end else begin
      x_out = '{16'h0004, 16'h0080, 16'h0, 16'h0, 16'h0};
      x_in  = '{16'h0, 16'h0, 16'h0020, 16'h0, 16'h0};
      x_busy = '{1, 1, 1, 1, 0}; x_done = '{0, 0, 0, 1, 0}; n = 5;
    end
    seq_start = 1; seq_skip_c = skip;
    cyc();
    for (int t = 0; t < n; t++) begin
      checks++;
      if (reg_out !== x_out[t] || reg_in !== x_in[t] || seq_busy !== x_busy[t] || seq_done !== x_done[t]) begin
        errors++;
        $display("FAIL seq_skip%0d_T+%0d: out=%h in=%h busy=%b done=%b required %h %h %b %b",
                 skip, t + 1, reg_out, reg_in, seq_busy, seq_done, x_out[t], x_in[t], x_busy[t], x_done[t]);
      end
      // manual controls toggled while busy must have no effect
      quiet();
      Gra = 1; Rin = 1; Rout = 1; seq_start = (t == 0);
      if (t == n - 1) quiet();
      cyc();
    end
    quiet();
  endtask

  task automatic test_baout();
    load(32'h18000000);
    Grb = 1; Rout = 1; BAout = 1; cyc(); quiet();
    checks++;
    if (reg_out !== 0 || ba_zero !== 1'b1) begin
      errors++; $display("FAIL baout_on: out=%h ba=%b required 0000 1", reg_out, ba_zero);
    end
    Grb = 1; Rout = 1; cyc(); quiet();
    checks++;
    if (reg_out !== 16'h0001 || ba_zero !== 1'b0) begin
      errors++; $display("FAIL baout_off: out=%h ba=%b required 0001 0", reg_out, ba_zero);
    end
    seq_start = 1; BAout = 1; cyc();
    checks++;
    if (reg_out !== 0 || ba_zero !== 1'b1 || seq_busy !== 1'b1) begin
      errors++; $display("FAIL baout_seq: out=%h ba=%b busy=%b required 0000 1 1", reg_out, ba_zero, seq_busy);
    end
    seq_start = 0;
    for (int i = 0; i < 5; i++) cyc();
    quiet();
  endtask

  task automatic test_abort();
    bit saw_done;
    load(32'h1A938000);
    seq_start = 1; cyc(); quiet();
    ir_load = 1; instr_in = 32'hFFFFFFFF; cyc(); quiet();
    checks++;
    if (opcode !== 5'd3 || reg_out !== 16'h0080) begin
      errors++; $display("FAIL ir_load_busy: opcode=%0d out=%h required 3 0080", opcode, reg_out);
    end
    clear = 1; cyc(); quiet();
    checks++;
    if (seq_busy !== 0 || reg_out !== 0 || reg_in !== 0 || seq_done !== 0) begin
      errors++; $display("FAIL abort_idle: busy=%b out=%h in=%h done=%b required 0 0 0 0", seq_busy, reg_out, reg_in, seq_done);
    end
    saw_done = 0;
    for (int i = 0; i < 4; i++) begin
      cyc();
      if (seq_done !== 1'b0 || seq_busy !== 1'b0) saw_done = 1;
    end
    checks++;
    if (saw_done) begin errors++; $display("FAIL abort_no_done: saw done/busy=1 required 0"); end
  endtask

  task automatic test_conflict();
    load(32'h1A938000);
    Gra = 1; Rin = 1; Rout = 1; cyc(); quiet();
    checks++;
    if (reg_in !== 16'h0020 || reg_out !== 16'h0020 || conflict !== 1'b1) begin
      errors++; $display("FAIL conflict: in=%h out=%h cf=%b required 0020 0020 1", reg_in, reg_out, conflict);
    end
    cyc();
    checks++;
    if (conflict !== 1'b0) begin errors++; $display("FAIL conflict_clear: cf=%b required 0", conflict); end
  endtask

  task automatic test_load_wins();
    load(32'h1A938000);
    seq_start = 1; ir_load = 1; instr_in = 32'h0007FFFF; cyc(); quiet();
    checks++;
    if (seq_busy !== 1'b0 || C_sign_extended !== 32'hFFFFFFFF) begin
      errors++; $display("FAIL load_wins: busy=%b C=%h required 0 FFFFFFFF", seq_busy, C_sign_extended);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      clear      = ($urandom_range(0, 39) == 0);
      ir_load    = ($urandom_range(0, 5) == 0);
      instr_in   = $urandom;
      if ($urandom_range(0, 3) == 0) instr_in = instr_in & 32'hF807FFFF;
      {Gra, Grb, Grc, Rin, Rout, BAout, seq_skip_c} = 7'($urandom);
      seq_start  = ($urandom_range(0, 3) == 0);
      cyc();
      checks++;
      if (reg_in !== e_in || reg_out !== e_out || reg_index !== e_idx || ba_zero !== e_ba ||
          conflict !== e_conf || seq_busy !== e_busy || seq_done !== e_done ||
          opcode !== 5'(m_ir >> 27) || C_sign_extended !== sext(m_ir)) begin
        errors++;
        $display("FAIL random_cyc%0d: in=%h out=%h idx=%0d ba=%b cf=%b busy=%b done=%b op=%0d C=%h required %h %h %0d %b %b %b %b %0d %h",
                 i, reg_in, reg_out, reg_index, ba_zero, conflict, seq_busy, seq_done, opcode, C_sign_extended,
                 e_in, e_out, e_idx, e_ba, e_conf, e_busy, e_done, 5'(m_ir >> 27), sext(m_ir));
      end
    end
    quiet();
  endtask

  initial begin
    quiet();
    test_reset();
    test_decode();
    test_sign_ext();
    test_sequence(0);
    test_sequence(1);
    test_baout();
    test_abort();
    test_conflict();
    test_load_wins();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
